decoder_stream: RTL and testbench

DECODER_STREAM -- requirements
Module: decoder_stream

---
 rtl/decoder_stream.sv | 110 +++++++++++
 tb/tb_decoder_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_stream.sv
// Streaming N-to-2**N one-hot decoder behind a 2-entry ready/valid FIFO.
// The output is decoded from the registered head entry; delivered words are counted by enable.
module decoder_stream #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_code,
  input  logic             in_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [(1<<N)-1:0] out_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       dec_count,
  output logic [7:0]       dis_count
);
  localparam int W = 1 << N;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e         state_q, state_d;
  logic           in_ready_q;
  logic [N-1:0]   head_code_q, head_code_d, tail_code_q, tail_code_d;
  logic           head_en_q, head_en_d, tail_en_q, tail_en_d;
  logic [7:0]     dec_q, dec_d, dis_q, dis_d;
  logic           push, pop;

  function automatic logic [W-1:0] decode(input logic [N-1:0] code, input logic en);
    logic [W-1:0] word;
    word = '0;
    if (en) word[code] = 1'b1;
    return word;
  endfunction

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    head_code_d = head_code_q;
    head_en_d   = head_en_q;
    tail_code_d = tail_code_q;
    tail_en_d   = tail_en_q;
    dec_d       = dec_q;
    dis_d       = dis_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = ONE;
          head_code_d = in_code;
          head_en_d   = in_en;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_code_d = in_code;
          head_en_d   = in_en;
        end else if (push) begin
          state_d     = FULL;
          tail_code_d = in_code;
          tail_en_d   = in_en;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = ONE;
          head_code_d = tail_code_q;
          head_en_d   = tail_en_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (pop) begin
      if (head_en_q) dec_d = dec_q + 8'd1;
      else           dis_d = dis_q + 8'd1;
    end
  end

  // Control state: reset clears occupancy, so buffered words are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      dec_q      <= '0;
      dis_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      dec_q      <= dec_d;
      dis_q      <= dis_d;
    end
  end

  always_ff @(posedge clk) begin
    head_code_q <= head_code_d;
    head_en_q   <= head_en_d;
    tail_code_q <= tail_code_d;
    tail_en_q   <= tail_en_d;
  end

  // Entry contents are only meaningful while occupied, so the output is gated by state.
  assign out_valid  = (state_q != EMPTY);
  assign out_onehot = out_valid ? decode(head_code_q, head_en_q) : '0;
  assign in_ready   = in_ready_q;
  assign dec_count  = dec_q;
  assign dis_count  = dis_q;
endmodule

// File: tb/tb_decoder_stream.sv
// Directed bench for decoder_stream (N=3): vector table for decode/disable,
// plus hand sequences for backpressure, drain, streaming, counter wrap and reset.
module tb_decoder_stream;
  localparam int N = 3;
  localparam int W = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_code;
  logic         in_en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_onehot;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   dec_count;
  logic [7:0]   dis_count;

  int n_cmp  = 0;
  int n_fail = 0;

  decoder_stream #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_en(in_en), .in_valid(in_valid),
    .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
    .out_ready(out_ready), .dec_count(dec_count), .dis_count(dis_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] code;
    logic         en;
    logic [W-1:0] exp_onehot;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_dec;
    logic [7:0] exp_dis;

    for (int i = 0; i < 8; i++) begin
      vecs[i].code       = 3'(i);
      vecs[i].en         = 1'b1;
      vecs[i].exp_onehot = 8'(1 << i);
    end
    vecs[8] = '{code: 3'd5, en: 1'b0, exp_onehot: 8'h00};
    vecs[9] = '{code: 3'd7, en: 1'b0, exp_onehot: 8'h00};

    rst = 1'b1; in_code = '0; in_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_onehot", 32'(out_onehot), 32'd0);
    check("rst_counts", {16'd0, dec_count, dis_count}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_release", 32'(in_ready), 32'd1);
    check("empty_after_release", 32'(out_valid), 32'd0);

    // Basic decode and disable: one word per cycle, visible one edge after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_code = vecs[i].code; in_en = vecs[i].en;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_onehot", i), 32'(out_onehot), 32'(vecs[i].exp_onehot));
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);
    check("dec_after_table", 32'(dec_count), 32'd8);
    check("dis_after_table", 32'(dis_count), 32'd2);
    exp_dec = 8'd8; exp_dis = 8'd2;

    // Backpressure: 2, 6 accepted, 1 held off.
    out_ready = 1'b0;
    in_valid = 1'b1; in_en = 1'b1; in_code = 3'd2;
    tick();
    check("bp1_onehot", 32'(out_onehot), 32'h04);
    check("bp1_ready", 32'(in_ready), 32'd1);
    in_code = 3'd6;
    tick();
    check("bp2_onehot", 32'(out_onehot), 32'h04);
    check("bp2_ready", 32'(in_ready), 32'd0);
    in_code = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_onehot", 32'(out_onehot), 32'h04);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    check("bp_no_count", 32'(dec_count), 32'(exp_dec));

    // Drain with code 1 still offered.
    out_ready = 1'b1;
    tick();
    check("drain1_onehot", 32'(out_onehot), 32'h40);
    check("drain1_ready", 32'(in_ready), 32'd1);
    tick();
    check("drain2_onehot", 32'(out_onehot), 32'h02);
    in_valid = 1'b0;
    tick();
    check("drain3_empty", 32'(out_valid), 32'd0);
    exp_dec = exp_dec + 8'd3;
    check("drain_dec", 32'(dec_count), 32'(exp_dec));

    // out_ready with nothing to deliver changes nothing.
    tick();
    tick();
    check("idle_dec", 32'(dec_count), 32'(exp_dec));
    check("idle_dis", 32'(dis_count), 32'(exp_dis));

    // Simultaneous transfers keep occupancy at one.
    in_valid = 1'b1; in_code = 3'd3;
    tick();
    check("sim_start", 32'(out_onehot), 32'h08);
    for (int i = 0; i < 10; i++) begin
      in_code = 3'(i);
      tick();
      check($sformatf("sim%0d_onehot", i), 32'(out_onehot), 32'(1 << (i % 8)));
      check($sformatf("sim%0d_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("sim_empty", 32'(out_valid), 32'd0);
    exp_dec = exp_dec + 8'd11;
    check("sim_dec", 32'(dec_count), 32'(exp_dec));

    // Counter wrap: exp_dec is 22 here; 234 more enabled words reach 256.
    in_valid = 1'b1;
    for (int i = 0; i < 234; i++) begin
      in_code = 3'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("wrap_dec", 32'(dec_count), 32'd0);
    check("wrap_dis", 32'(dis_count), 32'(exp_dis));

    // Fill to FULL, then reset between edges.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd7;
    tick();
    in_code = 3'd0;
    tick();
    check("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_onehot", 32'(out_onehot), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_counts", {16'd0, dec_count, dis_count}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_stale", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_code = 3'd4;
    tick();
    check("post_rst_word", 32'(out_onehot), 32'h10);
    in_valid = 1'b0;
    tick();
    check("post_rst_dec", 32'(dec_count), 32'd1);
    check("post_rst_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
